// File: rtl/gi_arb_pkg.sv
// Shared definitions for the gi FIFO read arbiter and the master FSM:
// state encoding, default sizing and channel index constants.
package gi_arb_pkg;

   localparam int unsigned GI_N_CH  = 3;
   localparam int unsigned GI_LEN_W = 16;
   localparam int unsigned GI_IDX_W = 2;

   // Channel index assignment used by the master FSM
   localparam int unsigned CH_IF   = 0;
   localparam int unsigned CH_KER  = 1;
   localparam int unsigned CH_BIAS = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/gi_arb_pick.sv
// Combinational winner select: the first set request found scanning upward
// from start_i, wrapping modulo N_CH. With start_i = 0 this is lowest-index priority.
module gi_arb_pick
   import gi_arb_pkg::*;
#(
   parameter int unsigned N_CH  = GI_N_CH,
   parameter int unsigned IDX_W = GI_IDX_W
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N_CH-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         cand = IDX_W'((32'(start_i) + k) % N_CH);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/gi_empn_rd_arbiter.sv
// Burst-locked arbiter sharing the gi FIFO read port among N_CH write modules.
// Define GI_ARB_RR_EN for round-robin selection; default is fixed lowest-index priority.
module gi_empn_rd_arbiter
   import gi_arb_pkg::*;
#(
   parameter int unsigned N_CH  = GI_N_CH,
   parameter int unsigned LEN_W = GI_LEN_W,
   parameter int unsigned IDX_W = GI_IDX_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_n_from_gi,
   output logic                  read_for_gi,
   input  logic [N_CH-1:0]       ch_req,
   input  logic [N_CH*LEN_W-1:0] ch_len,
   input  logic [N_CH-1:0]       ch_read,
   output logic [N_CH-1:0]       ch_empty_n,
   output logic [N_CH-1:0]       ch_grant,
   output logic [N_CH-1:0]       ch_done,
   output logic                  busy,
   output logic [IDX_W-1:0]      cur_ch,
   output logic                  proto_err
);

   arb_state_e       state_q, state_d;
   logic [N_CH-1:0]  grant_q, grant_d;
   logic [N_CH-1:0]  done_q, done_d;
   logic             busy_q, busy_d;
   logic [IDX_W-1:0] cur_ch_q, cur_ch_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [N_CH-1:0]  pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [IDX_W-1:0] pick_start;
   logic [LEN_W-1:0] len_sel;
   logic             accept_c;
   logic             last_c;
   logic             abort_c;
   logic             rd_err_c;

`ifdef GI_ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
   assign pick_start = IDX_W'(ptr_q + IDX_W'(1));
`else
   assign pick_start = '0;
`endif

   gi_arb_pick #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (ch_req),
      .start_i (pick_start),
      .gnt_o   (pick_oh),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign len_sel = ch_len[pick_idx*LEN_W +: LEN_W];

   // Gating toward the FIFO and write modules; forced low while reset is held
   assign ch_empty_n  = reset ? '0 : (grant_q & {N_CH{empty_n_from_gi}});
   assign read_for_gi = !reset && (|(ch_read & grant_q)) && empty_n_from_gi;
   assign accept_c    = read_for_gi;
   assign last_c      = accept_c && (cnt_q == len_q - LEN_W'(1));
   assign abort_c     = !ch_req[cur_ch_q];
   assign rd_err_c    = (|(ch_read & ~grant_q)) || ((|ch_read) && !empty_n_from_gi);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (pick_any) state_d = (len_sel == '0) ? ST_DONE : ST_XFER;
         ST_XFER: begin
            if (abort_c)     state_d = ST_IDLE;
            else if (last_c) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grant_d  = grant_q;
      done_d   = '0;
      cur_ch_d = cur_ch_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      err_d    = err_q | rd_err_c;
      busy_d   = (state_d != ST_IDLE);
`ifdef GI_ARB_RR_EN
      ptr_d    = ptr_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               cur_ch_d = pick_idx;
               len_d    = len_sel;
               cnt_d    = '0;
               if (len_sel == '0) done_d  = pick_oh;
               else               grant_d = pick_oh;
            end
         end
         ST_XFER: begin
            if (abort_c) begin
               grant_d  = '0;
               cnt_d    = '0;
               cur_ch_d = '0;
`ifdef GI_ARB_RR_EN
               ptr_d    = cur_ch_q;
`endif
            end else if (last_c) begin
               grant_d = '0;
               done_d  = grant_q;
               cnt_d   = '0;
            end else if (accept_c) begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         ST_DONE: begin
            cur_ch_d = '0;
            cnt_d    = '0;
`ifdef GI_ARB_RR_EN
            ptr_d    = cur_ch_q;
`endif
         end
         default: begin
            grant_d  = '0;
            cur_ch_d = '0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         cur_ch_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
`ifdef GI_ARB_RR_EN
         ptr_q    <= '0;
`endif
      end else begin
         grant_q  <= grant_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         cur_ch_q <= cur_ch_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`ifdef GI_ARB_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign ch_grant  = grant_q;
   assign ch_done   = done_q;
   assign busy      = busy_q;
   assign cur_ch    = cur_ch_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_gi_empn_rd_arbiter.sv
// Directed, table-driven bench for gi_empn_rd_arbiter (default fixed-priority build).
module tb_gi_empn_rd_arbiter;

   localparam int unsigned N_CH  = 3;
   localparam int unsigned LEN_W = 16;
   localparam int unsigned IDX_W = 2;

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  rd;
      logic        empn;
      logic [15:0] len;
      logic [2:0]  g;
      logic [2:0]  d;
      logic        r;
      logic        b;
      logic [1:0]  c;
   } vec_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  empty_n_from_gi;
   logic                  read_for_gi;
   logic [N_CH-1:0]       ch_req;
   logic [N_CH*LEN_W-1:0] ch_len;
   logic [N_CH-1:0]       ch_read;
   logic [N_CH-1:0]       ch_empty_n;
   logic [N_CH-1:0]       ch_grant;
   logic [N_CH-1:0]       ch_done;
   logic                  busy;
   logic [IDX_W-1:0]      cur_ch;
   logic                  proto_err;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   gi_empn_rd_arbiter #(.N_CH(N_CH), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .empty_n_from_gi (empty_n_from_gi),
      .read_for_gi     (read_for_gi),
      .ch_req          (ch_req),
      .ch_len          (ch_len),
      .ch_read         (ch_read),
      .ch_empty_n      (ch_empty_n),
      .ch_grant        (ch_grant),
      .ch_done         (ch_done),
      .busy            (busy),
      .cur_ch          (cur_ch),
      .proto_err       (proto_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] req, input logic [2:0] rd, input logic empn,
                               input logic [15:0] len, input logic [2:0] g, input logic [2:0] d,
                               input logic r, input logic b, input logic [1:0] c);
      vec_t v;
      v.req = req; v.rd = rd; v.empn = empn; v.len = len;
      v.g = g; v.d = d; v.r = r; v.b = b; v.c = c;
      return v;
   endfunction

   initial begin
      // single burst on ch1, len 4
      vecs.push_back(mk(3'b010, 3'b000, 1'b1, 16'd4, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      for (int j = 0; j < 4; j++)
         vecs.push_back(mk(3'b010, 3'b010, 1'b1, 16'd4, 3'b010, 3'b000, 1'b1, 1'b1, 2'd1));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd4, 3'b000, 3'b010, 1'b0, 1'b1, 2'd1));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd4, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      // same burst with FIFO empty every other cycle
      vecs.push_back(mk(3'b010, 3'b000, 1'b1, 16'd4, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      for (int j = 0; j < 8; j++) begin
         logic e;
         e = (j % 2 == 1);
         vecs.push_back(mk(3'b010, e ? 3'b010 : 3'b000, e, 16'd4, 3'b010, 3'b000, e, 1'b1, 2'd1));
      end
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd4, 3'b000, 3'b010, 1'b0, 1'b1, 2'd1));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd4, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      // contention, len 2: ch0, then ch1, then ch2
      vecs.push_back(mk(3'b111, 3'b000, 1'b1, 16'd2, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b111, 3'b001, 1'b1, 16'd2, 3'b001, 3'b000, 1'b1, 1'b1, 2'd0));
      vecs.push_back(mk(3'b111, 3'b001, 1'b1, 16'd2, 3'b001, 3'b000, 1'b1, 1'b1, 2'd0));
      vecs.push_back(mk(3'b110, 3'b000, 1'b1, 16'd2, 3'b000, 3'b001, 1'b0, 1'b1, 2'd0));
      vecs.push_back(mk(3'b110, 3'b000, 1'b1, 16'd2, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b110, 3'b010, 1'b1, 16'd2, 3'b010, 3'b000, 1'b1, 1'b1, 2'd1));
      vecs.push_back(mk(3'b110, 3'b010, 1'b1, 16'd2, 3'b010, 3'b000, 1'b1, 1'b1, 2'd1));
      vecs.push_back(mk(3'b100, 3'b000, 1'b1, 16'd2, 3'b000, 3'b010, 1'b0, 1'b1, 2'd1));
      vecs.push_back(mk(3'b100, 3'b000, 1'b1, 16'd2, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b100, 3'b100, 1'b1, 16'd2, 3'b100, 3'b000, 1'b1, 1'b1, 2'd2));
      vecs.push_back(mk(3'b100, 3'b100, 1'b1, 16'd2, 3'b100, 3'b000, 1'b1, 1'b1, 2'd2));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd2, 3'b000, 3'b100, 1'b0, 1'b1, 2'd2));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd2, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      // abort ch2 after 1 of 5 words: no done pulse
      vecs.push_back(mk(3'b100, 3'b000, 1'b1, 16'd5, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b100, 3'b100, 1'b1, 16'd5, 3'b100, 3'b000, 1'b1, 1'b1, 2'd2));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd5, 3'b100, 3'b000, 1'b0, 1'b1, 2'd2));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd5, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      // zero length: done pulse, no grant, no reads
      vecs.push_back(mk(3'b001, 3'b000, 1'b1, 16'd0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd0, 3'b000, 3'b001, 1'b0, 1'b1, 2'd0));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      // length changed mid-burst is ignored
      vecs.push_back(mk(3'b001, 3'b000, 1'b1, 16'd2, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk(3'b001, 3'b001, 1'b1, 16'd7, 3'b001, 3'b000, 1'b1, 1'b1, 2'd0));
      vecs.push_back(mk(3'b001, 3'b001, 1'b1, 16'd7, 3'b001, 3'b000, 1'b1, 1'b1, 2'd0));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd7, 3'b000, 3'b001, 1'b0, 1'b1, 2'd0));
      vecs.push_back(mk(3'b000, 3'b000, 1'b1, 16'd7, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0));

      reset = 1'b1;
      empty_n_from_gi = 1'b1;
      ch_req  = '0;
      ch_read = '0;
      ch_len  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst grant", 32'(ch_grant), 32'h0);
      chk("rst done", 32'(ch_done), 32'h0);
      chk("rst read", 32'(read_for_gi), 32'h0);
      chk("rst empty_n", 32'(ch_empty_n), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst cur_ch", 32'(cur_ch), 32'h0);
      chk("rst err", 32'(proto_err), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         ch_req          = vecs[i].req;
         ch_read         = vecs[i].rd;
         empty_n_from_gi = vecs[i].empn;
         ch_len          = {3{vecs[i].len}};
         @(negedge clk);
         chk($sformatf("v%0d grant", i), 32'(ch_grant), 32'(vecs[i].g));
         chk($sformatf("v%0d done", i), 32'(ch_done), 32'(vecs[i].d));
         chk($sformatf("v%0d read", i), 32'(read_for_gi), 32'(vecs[i].r));
         chk($sformatf("v%0d empty_n", i), 32'(ch_empty_n), 32'(vecs[i].g & {3{vecs[i].empn}}));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].b));
         chk($sformatf("v%0d cur_ch", i), 32'(cur_ch), 32'(vecs[i].c));
         chk($sformatf("v%0d err", i), 32'(proto_err), 32'h0);
         @(posedge clk);
         #1;
      end

      // read from a non-granted channel while ch1 holds the grant
      ch_req = 3'b010; ch_len = {3{16'd3}}; ch_read = 3'b000; empty_n_from_gi = 1'b1;
      @(posedge clk); #1;
      ch_read = 3'b001;
      @(negedge clk);
      chk("err grant", 32'(ch_grant), 32'h2);
      chk("err read blocked", 32'(read_for_gi), 32'h0);
      chk("err not yet", 32'(proto_err), 32'h0);
      @(posedge clk); #1;
      ch_read = 3'b000;
      @(negedge clk);
      chk("err set", 32'(proto_err), 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err sticky", 32'(proto_err), 32'h1);
      chk("err busy", 32'(busy), 32'h1);

      // reset mid-burst: gating drops at once, registers clear on the edge
      @(posedge clk); #1;
      ch_read = 3'b010;
      reset = 1'b1;
      @(negedge clk);
      chk("rst mid read", 32'(read_for_gi), 32'h0);
      chk("rst mid empty_n", 32'(ch_empty_n), 32'h0);
      @(posedge clk); #1;
      chk("rst mid grant", 32'(ch_grant), 32'h0);
      chk("rst mid done", 32'(ch_done), 32'h0);
      chk("rst mid busy", 32'(busy), 32'h0);
      chk("rst mid cur_ch", 32'(cur_ch), 32'h0);
      chk("rst mid err", 32'(proto_err), 32'h0);
      reset = 1'b0;
      ch_req = '0;
      ch_read = '0;
      @(posedge clk); #1;
      chk("post rst busy", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
